// File: rtl/pwm_ramp_duty_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_ramp_duty_gen
// Brief    : Operand generator for a PWM comparator. Produces a prescaled
//            free-running ramp and a button-driven saturating duty value.
//            A new duty is applied only at ramp wrap, so the PWM period that
//            is in progress never sees a mid-period change.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_ramp_duty_gen #(
  parameter int WIDTH     = 4,
  parameter int PRESCALE  = 8,
  parameter int DUTY_INIT = 8,
  parameter int STEP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [WIDTH-1:0] ramp,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] duty_pending,
  output logic             period_start,
  output logic             sat_hi,
  output logic             sat_lo
);

  // Prescaler is wide enough for any PRESCALE up to 65535.
  localparam int               PS_W        = 16;
  localparam logic [PS_W-1:0]  PS_LAST     = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INIT_VAL    = WIDTH'(DUTY_INIT);
  localparam logic [WIDTH:0]   STEP_EXT    = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_EXT     = {1'b0, MAX_VAL};
  localparam logic             SAT_HI_INIT = (INIT_VAL == MAX_VAL);
  localparam logic             SAT_LO_INIT = (INIT_VAL == '0);

  // Button synchronizers and edge-detect history.
  logic up_s1_q, up_s2_q, up_prev_q;
  logic dn_s1_q, dn_s2_q, dn_prev_q;
  logic up_p, down_p;

  // Ramp, prescaler and duty state.
  logic [PS_W-1:0]  presc_q, presc_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] dp_q, dp_d;
  logic             ps_q, ps_d;
  logic             sat_hi_q, sat_hi_d;
  logic             sat_lo_q, sat_lo_d;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             tick, wrap;

  // Two-flop synchronizers followed by one history flop per button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_s1_q   <= 1'b0;
      up_s2_q   <= 1'b0;
      up_prev_q <= 1'b0;
      dn_s1_q   <= 1'b0;
      dn_s2_q   <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      up_s1_q   <= btn_up;
      up_s2_q   <= up_s1_q;
      up_prev_q <= up_s2_q;
      dn_s1_q   <= btn_down;
      dn_s2_q   <= dn_s1_q;
      dn_prev_q <= dn_s2_q;
    end
  end

  // Single-cycle press pulses; a held button yields only one pulse.
  assign up_p   = up_s2_q & ~up_prev_q;
  assign down_p = dn_s2_q & ~dn_prev_q;

  // Pending duty: one extra bit of headroom so the clamp can see overflow
  // and underflow instead of wrapping.
  always_comb begin
    sum_ext  = {1'b0, dp_q} + STEP_EXT;
    diff_ext = {1'b0, dp_q} - STEP_EXT;
    dp_d     = dp_q;
    if (up_p && !down_p) begin
      dp_d = (sum_ext > MAX_EXT) ? MAX_VAL : sum_ext[WIDTH-1:0];
    end else if (down_p && !up_p) begin
      dp_d = diff_ext[WIDTH] ? '0 : diff_ext[WIDTH-1:0];
    end
    sat_hi_d = (dp_d == MAX_VAL);
    sat_lo_d = (dp_d == '0);
  end

  // Prescaler, ramp and wrap-time duty transfer.
  always_comb begin
    tick    = en && (presc_q == PS_LAST);
    wrap    = tick && (ramp_q == MAX_VAL);
    presc_d = presc_q;
    ramp_d  = ramp_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
    end
    if (tick) begin
      ramp_d = ramp_q + WIDTH'(1);
    end
    // dp_q (not dp_d) so an update landing on the wrap edge waits a period.
    duty_d = wrap ? dp_q : duty_q;
    ps_d   = wrap;
  end

  // Main state register; reset discards any in-flight duty change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      ramp_q   <= '0;
      duty_q   <= INIT_VAL;
      dp_q     <= INIT_VAL;
      ps_q     <= 1'b0;
      sat_hi_q <= SAT_HI_INIT;
      sat_lo_q <= SAT_LO_INIT;
    end else begin
      presc_q  <= presc_d;
      ramp_q   <= ramp_d;
      duty_q   <= duty_d;
      dp_q     <= dp_d;
      ps_q     <= ps_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
    end
  end

  assign ramp         = ramp_q;
  assign duty         = duty_q;
  assign duty_pending = dp_q;
  assign period_start = ps_q;
  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_duty_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_ramp_duty_gen
// Brief    : Scoreboard bench for pwm_ramp_duty_gen (WIDTH=4, PRESCALE=4,
//            DUTY_INIT=8, STEP=1). Stimulus queues time-stamped expectations;
//            a monitor compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_ramp_duty_gen;

  localparam int S_RAMP = 0;
  localparam int S_DUTY = 1;
  localparam int S_DP   = 2;
  localparam int S_PS   = 3;
  localparam int S_SHI  = 4;
  localparam int S_SLO  = 5;

  logic       clk, rst, en, btn_up, btn_down;
  logic [3:0] ramp, duty, duty_pending;
  logic       period_start, sat_hi, sat_lo;

  pwm_ramp_duty_gen #(
    .WIDTH    (4),
    .PRESCALE (4),
    .DUTY_INIT(8),
    .STEP     (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .ramp        (ramp),
    .duty        (duty),
    .duty_pending(duty_pending),
    .period_start(period_start),
    .sat_hi      (sat_hi),
    .sat_lo      (sat_lo)
  );

  typedef struct {
    int         at;
    int         sig;
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   dp_m;
  int   t0;
  int   k0;
  int   tr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp expectations.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] sample(input int sig);
    case (sig)
      S_RAMP:  return ramp;
      S_DUTY:  return duty;
      S_DP:    return duty_pending;
      S_PS:    return {3'b000, period_start};
      S_SHI:   return {3'b000, sat_hi};
      default: return {3'b000, sat_lo};
    endcase
  endfunction

  function automatic void push_abs(input int at, input int sig, input int val, input string name);
    exp_t e;
    e.at   = at;
    e.sig  = sig;
    e.val  = 4'(val);
    e.name = name;
    sbq.push_back(e);
  endfunction

  // Expectation observed after n more rising edges.
  function automatic void expect_in(input int n, input int sig, input int val, input string name);
    push_abs(cyc + n, sig, val, name);
  endfunction

  // Monitor: on every falling edge, retire all expectations that are due.
  initial begin
    logic [3:0] act;
    forever begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].at <= cyc) begin
          act = sample(sbq[i].sig);
          checks++;
          if (act !== sbq[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", sbq[i].name, cyc, act, sbq[i].val);
          end
          sbq.delete(i);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  // One button action with the reference model of the clamped pending duty.
  task automatic press(input logic up, input logic dn, input int hold);
    int old_v;
    old_v = dp_m;
    if (up && !dn)      dp_m = (dp_m + 1 > 15) ? 15 : dp_m + 1;
    else if (dn && !up) dp_m = (dp_m - 1 < 0) ? 0 : dp_m - 1;
    btn_up   = up;
    btn_down = dn;
    expect_in(2, S_DP, old_v, "dp_before");
    expect_in(3, S_DP, dp_m, "dp_after");
    expect_in(3, S_SHI, (dp_m == 15) ? 1 : 0, "sat_hi");
    expect_in(3, S_SLO, (dp_m == 0) ? 1 : 0, "sat_lo");
    if (hold > 10) expect_in(hold, S_DP, dp_m, "dp_held");
    step(hold);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    step(4);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    dp_m = 8;
    repeat (3) @(posedge clk);

    // Asynchronous reset: outputs settle before any further clock edge.
    @(posedge clk);
    #2;
    rst = 1'b1;
    expect_in(0, S_RAMP, 0, "rst_ramp");
    expect_in(0, S_DUTY, 8, "rst_duty");
    expect_in(0, S_DP,   8, "rst_dp");
    expect_in(0, S_PS,   0, "rst_ps");
    expect_in(0, S_SHI,  0, "rst_sat_hi");
    expect_in(0, S_SLO,  0, "rst_sat_lo");
    @(negedge clk);
    #1;
    step(1);
    rst = 1'b0;
    en  = 1'b1;
    t0  = cyc;

    // Ramp timing from reset release.
    push_abs(t0 + 3,   S_RAMP, 0,  "ramp_pre_first_tick");
    push_abs(t0 + 4,   S_RAMP, 1,  "ramp_first_tick");
    push_abs(t0 + 60,  S_RAMP, 15, "ramp_top");
    push_abs(t0 + 63,  S_PS,   0,  "ps_before_wrap");
    push_abs(t0 + 64,  S_RAMP, 0,  "ramp_wrap");
    push_abs(t0 + 64,  S_PS,   1,  "ps_wrap1");
    push_abs(t0 + 65,  S_PS,   0,  "ps_one_cycle");
    push_abs(t0 + 68,  S_RAMP, 1,  "ramp_after_wrap");
    push_abs(t0 + 127, S_PS,   0,  "ps_before_wrap2");
    push_abs(t0 + 128, S_PS,   1,  "ps_wrap2");

    // Deferred duty: three presses mid-period, applied at the next wrap.
    wait_until(t0 + 70);
    push_abs(t0 + 127, S_DUTY, 8,  "duty_held");
    push_abs(t0 + 128, S_DUTY, 11, "duty_at_wrap");
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 4);

    // Pending update on the wrap edge itself: duty takes the old value.
    wait_until(t0 + 189);
    push_abs(t0 + 192, S_DUTY, 11, "duty_wrap_edge_old");
    push_abs(t0 + 192, S_PS,   1,  "ps_wrap3");
    push_abs(t0 + 256, S_DUTY, 12, "duty_next_period");
    press(1'b1, 1'b0, 4);
    wait_until(t0 + 257);

    // Saturation at both ends, then a long hold yielding one step.
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 4);
    for (int i = 0; i < 20; i++) press(1'b0, 1'b1, 4);
    press(1'b1, 1'b0, 100);

    // Simultaneous presses cancel.
    press(1'b1, 1'b1, 4);

    // Enable low at ramp=5 with prescaler at 0.
    while (((cyc - t0) % 64) != 20) step(1);
    en = 1'b0;
    k0 = cyc;
    expect_in(1,  S_RAMP, 5, "ramp_hold_1");
    expect_in(25, S_RAMP, 5, "ramp_hold_25");
    expect_in(50, S_RAMP, 5, "ramp_hold_50");
    expect_in(10, S_PS,   0, "ps_hold_10");
    expect_in(40, S_PS,   0, "ps_hold_40");
    step(5);
    press(1'b1, 1'b0, 4);
    wait_until(k0 + 50);
    en = 1'b1;
    expect_in(3, S_RAMP, 5, "ramp_resume_pre");
    expect_in(4, S_RAMP, 6, "ramp_resume");

    // Reset mid-operation with a press in flight.
    while (dp_m < 12) press(1'b1, 1'b0, 4);
    btn_up = 1'b1;
    step(1);
    rst    = 1'b1;
    btn_up = 1'b0;
    dp_m   = 8;
    expect_in(0, S_RAMP, 0, "rst2_ramp");
    expect_in(0, S_DUTY, 8, "rst2_duty");
    expect_in(0, S_DP,   8, "rst2_dp");
    expect_in(0, S_PS,   0, "rst2_ps");
    step(1);
    rst = 1'b0;
    tr  = cyc;
    push_abs(tr + 3, S_RAMP, 0, "rst2_pre_tick");
    push_abs(tr + 4, S_RAMP, 1, "rst2_first_tick");
    push_abs(tr + 5, S_DP,   8, "rst2_dp_aborted");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 300 && sbq.size() != 0; i++) step(1);
    if (sbq.size() != 0) begin
      $display("FAIL drain pending=%0d exp=0", sbq.size());
      errors += sbq.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_ramp_duty_gen.md
Name: pwm_ramp_duty_gen

Overview:
- Upstream stage of the PWM comparator; generates both of its operands.
- A prescaled free-running WIDTH-bit ramp feeds the comparator's `in` input.
- A button-controlled, saturating duty register feeds the comparator's `ref` input.
- Duty changes take effect only at ramp wrap, so the downstream PWM output never glitches mid-period.

Parameters:
- WIDTH, 4, bit width of ramp and duty; matches comparator operand width.
- PRESCALE, 8, clk cycles per ramp step; legal range 1..65535.
- DUTY_INIT, 8, reset value of pending and active duty; must be ≤ 2^WIDTH-1.
- STEP, 1, duty increment/decrement per button press; legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  ramp run enable (level).
- btn_up  input  1  duty-increase request, debounced level, asynchronous to clk.
- btn_down  input  1  duty-decrease request, debounced level, asynchronous to clk.
- ramp  output  WIDTH  current ramp value; drives comparator `in`.
- duty  output  WIDTH  active duty; drives comparator `ref`.
- duty_pending  output  WIDTH  duty value to be applied at the next wrap.
- period_start  output  1  one-cycle pulse, high in the first cycle ramp reads 0 after a wrap.
- sat_hi  output  1  high while duty_pending == 2^WIDTH-1.
- sat_lo  output  1  high while duty_pending == 0.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-high, rst.
  - On rst: prescaler=0, ramp=0, period_start=0, synchronizer and edge-detect flops=0, duty=duty_pending=DUTY_INIT; sat_hi/sat_lo follow from DUTY_INIT.
  - rst asserted mid-operation aborts everything immediately, including a pending duty change.
- Button input path:
  - Each button passes through a 2-flop synchronizer, then a rising-edge detector (1 flop).
  - An edge produces a one-cycle internal pulse: up_p or down_p.
  - Latency from btn rising to duty_pending update is 3 clk edges.
  - Held buttons produce only one step; no auto-repeat.
- Pending duty update (every cycle, independent of en):
  - up_p & !down_p: duty_pending = min(duty_pending+STEP, 2^WIDTH-1).
  - down_p & !up_p: duty_pending = max(duty_pending-STEP, 0).
  - Both or neither: no change.
  - Arithmetic is done in WIDTH+1 bits, then clamped; never wraps.
- Prescaler:
  - Counts 0..PRESCALE-1 while en=1.
  - tick = en & (prescaler == PRESCALE-1); on tick, prescaler returns to 0.
  - PRESCALE=1 gives tick = en every cycle.
  - en=0: prescaler and ramp hold their values; no tick, no wrap.
- Ramp:
  - On tick, ramp = ramp+1 modulo 2^WIDTH.
  - Period = PRESCALE * 2^WIDTH clk cycles with en continuously high.
- Wrap (tick while ramp == 2^WIDTH-1):
  - Same edge: ramp←0, duty←duty_pending, period_start←1.
  - period_start clears on the next edge.
  - If duty_pending updates on the wrap edge itself, duty takes the pre-update value; the new value waits one period.
- Outputs: all outputs are registered; no combinational input-to-output path.
- Downstream contract: the comparator drives high while ramp > duty.
  - duty = 2^WIDTH-1 gives a constant-low PWM.
  - duty = 0 gives high for 2^WIDTH-1 of 2^WIDTH steps.

Test Plan:
1. Reset (WIDTH=4, PRESCALE=4, DUTY_INIT=8): assert rst mid-cycle without a clock edge → ramp=0, duty=duty_pending=8, period_start=0, sat_hi=sat_lo=0 immediately.
2. Ramp timing, en=1 after reset: ramp=1 after 4 edges, 15 after 60 edges, 0 after 64 edges with period_start high exactly 1 cycle; next pulse 64 cycles later.
3. Deferred duty: pulse btn_up 3 times mid-period → duty_pending 8→11 (each 3 edges after its rise), duty stays 8 until the next wrap, then duty=11 together with period_start.
4. Saturation: 10 btn_up presses from 8 → duty_pending=15, sat_hi=1. Then 20 btn_down presses → duty_pending=0, sat_lo=1, no wrap-around. Held btn_up for 100 cycles → exactly one step.
5. Simultaneous and enable: btn_up and btn_down rising on the same edge → duty_pending unchanged. en=0 at ramp=5 for 50 cycles → ramp stays 5, no period_start, yet btn_up still moves duty_pending. Restoring en → ramp resumes at 5→6 after a full PRESCALE count.
6. Reset mid-operation: duty_pending=12, duty=8, ramp=9 → rst pulse → duty=duty_pending=8, ramp=0, prescaler restarts; first tick is 4 edges after rst deasserts.
